// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types for the unified memory arbiter: response owner states and requester identity.
package unified_memory_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_D  = 2'd2
   } resp_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } requester_t;

   // Bits needed to hold a streak count in 0..max_streak.
   function automatic int streak_bits(input int max_streak);
      return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/unified_memory_arbiter_starvation_guard.sv
// Counts consecutive D grants taken while IF is waiting; raises force_if once the
// run reaches max_d_streak so the next contested cycle goes to IF.
module starvation_guard
   import unified_memory_arbiter_pkg::*;
#(
   parameter int max_d_streak = 4
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic if_req,
   input  logic if_gnt,
   input  logic d_gnt,
   output logic force_if
);

   localparam int SW = streak_bits(max_d_streak);
   localparam logic [SW-1:0] STREAK_MAX = SW'(max_d_streak);

   logic [SW-1:0] streak;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         streak <= '0;
      end else if (if_gnt || !if_req) begin
         streak <= '0;
      end else if (d_gnt && (streak != STREAK_MAX)) begin
         streak <= streak + SW'(1);
      end
   end

   assign force_if = (streak == STREAK_MAX);

endmodule

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store.
// Optional wait-cycle counters are built when ARB_PERF_COUNTERS_EN is defined.
module unified_memory_arbiter
   import unified_memory_arbiter_pkg::*;
#(
   parameter int data_bits           = 32,
   parameter int memory_size         = 1024,
   parameter int memory_address_bits = $clog2(memory_size),
   parameter int max_d_streak        = 4
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic                           if_req,
   input  logic [memory_address_bits-1:0] if_addr,
   output logic                           if_gnt,
   output logic                           if_rvalid,
   output logic [data_bits-1:0]           if_rdata,
   input  logic                           d_req,
   input  logic                           d_we,
   input  logic [memory_address_bits-1:0] d_addr,
   input  logic [data_bits-1:0]           d_wdata,
   output logic                           d_gnt,
   output logic                           d_rvalid,
   output logic [data_bits-1:0]           d_rdata,
   output logic                           mem_en,
   output logic                           mem_we,
   output logic [memory_address_bits-1:0] mem_addr,
   output logic [data_bits-1:0]           mem_wdata,
   input  logic [data_bits-1:0]           mem_rdata
`ifdef ARB_PERF_COUNTERS_EN
   ,
   output logic [31:0]                    if_wait_cycles,
   output logic [31:0]                    d_wait_cycles
`endif
);

   requester_t  winner;
   resp_state_t state;
   resp_state_t state_next;
   logic        force_if;

   starvation_guard #(
      .max_d_streak(max_d_streak)
   ) u_guard (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .if_req   (if_req),
      .if_gnt   (if_gnt),
      .d_gnt    (d_gnt),
      .force_if (force_if)
   );

   always_comb begin
      winner = REQ_D;
      if (if_req && (!d_req || force_if)) begin
         winner = REQ_IF;
      end
   end

   // Grants are held low while reset is asserted so every output reads zero.
   assign if_gnt = RESET_N & if_req & (winner == REQ_IF);
   assign d_gnt  = RESET_N & d_req  & (winner == REQ_D);

   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = d_gnt & d_we;
   assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
   assign mem_wdata = d_gnt ? d_wdata : '0;

   always_comb begin
      state_next = IDLE;
      if (if_gnt) begin
         state_next = RESP_IF;
      end else if (d_gnt && !d_we) begin
         state_next = RESP_D;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign if_rvalid = (state == RESP_IF);
   assign d_rvalid  = (state == RESP_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef ARB_PERF_COUNTERS_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         if_wait_cycles <= '0;
         d_wait_cycles  <= '0;
      end else begin
         if (if_req && !if_gnt && (if_wait_cycles != '1)) begin
            if_wait_cycles <= if_wait_cycles + 32'd1;
         end
         if (d_req && !d_gnt && (d_wait_cycles != '1)) begin
            d_wait_cycles <= d_wait_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
